// File: rtl/rs_drv_pkg.sv
// Shared definitions for the RS_NAND pulse driver: FSM state codes and a
// counter-width helper.
package rs_drv_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SET  = 2'd1;
  localparam logic [1:0] RST  = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: two-flop synchroniser, stable-count debounce and a
// registered one-cycle pulse on each rising edge of the debounced level.
module btn_debounce
  import rs_drv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d, deb_dly_q, rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // A full count flips the level; the sample seen on that edge is not counted.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (cnt_q == CNT_MAX) begin
      deb_d = ~deb_q;
    end else if (sync2_q != deb_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      rise_q    <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      rise_q    <= deb_q & ~deb_dly_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/rs_pulse_driver.sv
// Turns debounced set/reset presses into bounded active-low Sn/Rn pulses,
// never driving both low, with a mandatory hold gap between pulses.
module rs_pulse_driver
  import rs_drv_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 3,
  parameter int GAP_CYCLES      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_rst,
  output logic Sn,
  output logic Rn,
  output logic busy,
  output logic conflict,
  output logic dropped
);

  localparam int CMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW   = cnt_w(CMAX);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GAP_CYCLES - 1);

  logic          set_req, rst_req;
  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic          sn_q, rn_q, busy_q, conflict_q, dropped_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_set),
    .rise_o (set_req)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_rst),
    .rise_o (rst_req)
  );

  // Outputs are loaded together with the state they belong to, so Sn/Rn are
  // glitch-free and only one of them can ever be low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sn_q       <= 1'b1;
      rn_q       <= 1'b1;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      conflict_q <= 1'b0;
      dropped_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (set_req && rst_req) begin
            conflict_q <= 1'b1;
          end else if (set_req) begin
            state_q <= SET;
            sn_q    <= 1'b0;
            busy_q  <= 1'b1;
          end else if (rst_req) begin
            state_q <= RST;
            rn_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SET, RST: begin
          dropped_q <= set_req | rst_req;
          if (cnt_q == P_LAST) begin
            state_q <= GAP;
            cnt_q   <= '0;
            sn_q    <= 1'b1;
            rn_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          dropped_q <= set_req | rst_req;
          if (cnt_q == G_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          sn_q    <= 1'b1;
          rn_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Sn       = sn_q;
  assign Rn       = rn_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_rs_pulse_driver.sv
// Directed bench for rs_pulse_driver: a timestamp/window model checked every
// cycle, plus literal expectations on pulse latency, widths and event counts.
module tb_rs_pulse_driver;

  localparam int D = 4;
  localparam int P = 3;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic Sn, Rn, busy, conflict, dropped;

  rs_pulse_driver #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_set  (btn_set),
    .btn_rst  (btn_rst),
    .Sn       (Sn),
    .Rn       (Rn),
    .busy     (busy),
    .conflict (conflict),
    .dropped  (dropped)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state. cyc numbers rising edges. A level is accepted when the four
  // samples taken 6..3 edges back all disagree with it; the sample right
  // after an acceptance is not counted, so the next window opens 5 edges on.
  int         cyc = 0;
  logic [7:0] hs = '0, hr = '0;
  logic       dm_s = 1'b0, dm_r = 1'b0;
  int         blk_s = 0, blk_r = 0;
  int         fire_s = -1, fire_r = -1;
  int         ps = -100;
  bit         ps_set = 1'b0;
  int         idle_from = 0;
  int         conf_e = -1, drop_e = -1;
  bit         sr, rr;
  logic       sn_e, rn_e, busy_e;

  // Observations, cleared per test.
  int sn_first = -1, rn_first = -1;
  int sn_lo = 0, rn_lo = 0, busy_cnt = 0, conf_cnt = 0, drop_cnt = 0;

  task automatic clear_obs();
    sn_first = -1; rn_first = -1;
    sn_lo = 0; rn_lo = 0; busy_cnt = 0; conf_cnt = 0; drop_cnt = 0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      hs = '0; hr = '0; dm_s = 1'b0; dm_r = 1'b0;
      blk_s = 0; blk_r = 0; fire_s = -1; fire_r = -1;
      ps = -100; idle_from = 0; conf_e = -1; drop_e = -1;
    end else begin
      sr = (fire_s == cyc);
      rr = (fire_r == cyc);
      if (sr || rr) begin
        if (cyc < idle_from) drop_e = cyc;
        else if (sr && rr) conf_e = cyc;
        else begin
          ps = cyc; ps_set = sr; idle_from = cyc + P + G + 1;
        end
      end
      hs = {hs[6:0], btn_set};
      hr = {hr[6:0], btn_rst};
      if (cyc >= blk_s && hs[6:3] == {4{~dm_s}}) begin
        dm_s = ~dm_s; blk_s = cyc + 5;
        if (dm_s) fire_s = cyc + 2;
      end
      if (cyc >= blk_r && hr[6:3] == {4{~dm_r}}) begin
        dm_r = ~dm_r; blk_r = cyc + 5;
        if (dm_r) fire_r = cyc + 2;
      end
    end
    sn_e   = !(ps_set && cyc >= ps && cyc < ps + P);
    rn_e   = !(!ps_set && cyc >= ps && cyc < ps + P);
    busy_e = (cyc >= ps && cyc < ps + P + G);
    #1;
    chk("Sn", Sn, sn_e);
    chk("Rn", Rn, rn_e);
    chk("busy", busy, busy_e);
    chk("conflict", conflict, int'(conf_e == cyc));
    chk("dropped", dropped, int'(drop_e == cyc));
    chk("sn_rn_never_both_low", Sn | Rn, 1);
    if (!Sn) begin sn_lo++; if (sn_first < 0) sn_first = cyc; end
    if (!Rn) begin rn_lo++; if (rn_first < 0) rn_first = cyc; end
    if (busy) busy_cnt++;
    if (conflict) conf_cnt++;
    if (dropped) drop_cnt++;
  end

  int p, settle;
  bit hit;

  initial begin
    // Reset values before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_Sn", Sn, 1);
    chk("rst_Rn", Rn, 1);
    chk("rst_busy", busy, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_dropped", dropped, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean set press held 20 cycles.
    clear_obs();
    @(negedge clk); btn_set = 1'b1; p = cyc + 1;
    repeat (20) @(negedge clk); btn_set = 1'b0;
    repeat (20) @(negedge clk);
    chk("t1_sn_latency", sn_first - p, 8);
    chk("t1_sn_width", sn_lo, 3);
    chk("t1_rn_quiet", rn_lo, 0);
    chk("t1_busy_width", busy_cnt, 5);

    // Bouncing reset button, then stable high.
    clear_obs();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); btn_rst = ((i % 4) < 2);
    end
    @(negedge clk); btn_rst = 1'b1; settle = cyc + 1;
    repeat (20) @(negedge clk); btn_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t2_rn_latency", rn_first - settle, 8);
    chk("t2_rn_width", rn_lo, 3);
    chk("t2_sn_quiet", sn_lo, 0);

    // Both buttons on the same clock.
    clear_obs();
    @(negedge clk); btn_set = 1'b1; btn_rst = 1'b1;
    repeat (20) @(negedge clk); btn_set = 1'b0; btn_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t3_conflict_count", conf_cnt, 1);
    chk("t3_sn_quiet", sn_lo, 0);
    chk("t3_rn_quiet", rn_lo, 0);
    chk("t3_busy_quiet", busy_cnt, 0);

    // Reset request landing in GAP is dropped; a later one is served.
    clear_obs();
    @(negedge clk); btn_set = 1'b1;
    repeat (4) @(negedge clk); btn_rst = 1'b1;
    repeat (16) @(negedge clk); btn_set = 1'b0;
    repeat (4) @(negedge clk); btn_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_dropped_count", drop_cnt, 1);
    chk("t4_sn_width", sn_lo, 3);
    chk("t4_rn_quiet", rn_lo, 0);
    clear_obs();
    @(negedge clk); btn_rst = 1'b1; p = cyc + 1;
    repeat (20) @(negedge clk); btn_rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_rn_latency", rn_first - p, 8);
    chk("t4_rn_width", rn_lo, 3);
    chk("t4_no_drop", drop_cnt, 0);

    // Asynchronous reset during the second Sn-low cycle.
    clear_obs();
    @(negedge clk); btn_set = 1'b1; p = cyc + 1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk); #1;
      if (cyc == p + 9) hit = 1'b1;
    end
    chk("t5_reached_pulse", int'(hit), 1);
    chk("t5_sn_low_before_reset", sn_lo, 2);
    #1 rst_n = 1'b0; btn_set = 1'b0;
    #1;
    chk("t5_async_Sn", Sn, 1);
    chk("t5_async_Rn", Rn, 1);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_conflict", conflict, 0);
    chk("t5_async_dropped", dropped, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    repeat (50) @(negedge clk);
    chk("t5_no_sn_after", sn_lo, 0);
    chk("t5_no_rn_after", rn_lo, 0);
    chk("t5_idle_after", busy_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rs_pulse_driver.md
Name: rs_pulse_driver

Overview:
- Upstream stage for the RS_NAND latch.
- Turns two raw push-buttons (set, reset) into clean active-low Sn/Rn pulses for the latch.
- Synchronises and debounces both buttons, then issues one bounded-width pulse per press.
- Never drives Sn=Rn=0, so the latch is never put in its undefined state, and always returns to hold (Sn=Rn=1) between pulses.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a new button level (>=1).
- PULSE_CYCLES, 3, cycles Sn or Rn is held low per accepted press (>=1).
- GAP_CYCLES, 2, minimum hold cycles (Sn=Rn=1) after each pulse before the next may start (>=1).

Ports:
- clk  input  1  system clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_set  input  1  raw set button, active-high, asynchronous to clk.
- btn_rst  input  1  raw reset button, active-high, asynchronous to clk.
- Sn  output  1  active-low set to RS_NAND; registered.
- Rn  output  1  active-low reset to RS_NAND; registered.
- busy  output  1  high while in SET, RST or GAP.
- conflict  output  1  one-cycle pulse: both presses accepted in the same cycle.
- dropped  output  1  one-cycle pulse: press accepted while busy and discarded.

Behaviour:
- Reset values (asynchronous, immediate on rst_n=0):
  - Sn=1, Rn=1, busy=0, conflict=0, dropped=0.
  - FSM in IDLE.
  - Sync flops, debounced levels and all counters are 0.
- Synchroniser: two flops per button.
- Debounce, per button:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - Counter increments while the synced level differs from the debounced level and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Request: one-cycle pulse on each rising edge of a debounced level. Falling edges generate nothing.
- Latency: Sn (or Rn) goes low on the clock edge DEBOUNCE_CYCLES+4 after the first edge that samples a clean high on the button.
  - 2 cycles synchroniser, DEBOUNCE_CYCLES debounce, 1 edge detect, 1 output register.
- FSM states: IDLE, SET, RST, GAP. The pulse counter is shared and clears on every state entry.
- IDLE (Sn=Rn=1, busy=0):
  - set_req only -> SET.
  - rst_req only -> RST.
  - Both in the same cycle -> conflict=1 for one cycle, stay IDLE, no drive.
- SET (Sn=0, Rn=1): exactly PULSE_CYCLES cycles, then GAP.
- RST (Sn=1, Rn=0): exactly PULSE_CYCLES cycles, then GAP.
- GAP (Sn=Rn=1): exactly GAP_CYCLES cycles, then IDLE.
  - A request arriving in the final GAP cycle is dropped. Requests are never queued.
- Requests accepted in SET/RST/GAP -> dropped=1 for one cycle. State and outputs are unaffected.
- Invariant: (Sn|Rn)==1 every cycle, including the reset release cycle.
- Bounce: any bounce shorter than DEBOUNCE_CYCLES produces no request. A held button produces exactly one pulse.
- Reset mid-pulse: Sn/Rn return to 1 asynchronously; the latch keeps its last state.
- Button held across rst_n release: debounces to 1 and yields one request DEBOUNCE_CYCLES+4 cycles after release. This is intended.

Decomposition:
- Shared package rs_drv_pkg holds:
  - state encoding localparams: IDLE=2'd0, SET=2'd1, RST=2'd2, GAP=2'd3;
  - a counter-width helper.
- Sub-module btn_debounce (synchroniser + debounce + rise-edge pulse, parameter DEBOUNCE_CYCLES).
  - Instantiated twice.
  - The top level holds the FSM and output registers.

Test Plan:
- Use DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, GAP_CYCLES=2.
- Clean set press, held 20 cycles -> Sn low for exactly 3 cycles starting 8 cycles after the press, Rn=1 throughout, busy high 5 cycles, one pulse only.
- btn_rst bouncing 1/0 every 2 cycles for 12 cycles, then stable high -> no Rn pulse during bounce; one 3-cycle Rn pulse 8 cycles after it settles.
- btn_set and btn_rst rising on the same clock -> conflict=1 for one cycle, Sn=Rn=1 throughout, FSM stays IDLE.
- Set press, then reset press whose request lands during GAP -> dropped=1 for one cycle, no Rn pulse; a reset press after IDLE returns -> Rn pulse.
- Assert rst_n=0 on the 2nd Sn-low cycle -> Sn=1 immediately without waiting for a clock edge, all outputs at reset values; after release with buttons low, no pulse appears for 50 cycles.
- Assertion across all tests: never Sn=0 and Rn=0 together.
